// File: rtl/lfsr_checker.sv
// Locks onto the 12-bit Fibonacci delay-generator sequence and flags/counts deviations once locked.
// Latency: all outputs registered, 1 cycle after the sampled word; no backpressure (consumes every valid word).
module lfsr_checker #(
    parameter logic [11:0] SEED       = 12'hB76,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    input  logic        err_clr,
    output logic        locked,
    output logic        mismatch,
    output logic [15:0] err_count,
    output logic [15:0] match_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_e;

    localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];
    localparam logic [3:0] LOSS_N = LOSS_COUNT[3:0];

    state_e      state_q, state_d;
    logic [11:0] exp_q, exp_d;
    logic [3:0]  hits_q, hits_d;
    logic [3:0]  miss_q, miss_d;
    logic        mismatch_q, mismatch_d;
    logic [15:0] err_count_q, err_count_d;
    logic [15:0] match_count_q, match_count_d;

    function automatic logic [11:0] lfsr_next(input logic [11:0] x);
        return (x == 12'h000) ? SEED : {x[10:0], x[11] ^ x[10]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        hits_d        = hits_q;
        miss_d        = miss_q;
        mismatch_d    = 1'b0;
        // Clear first, so a coincident counted event lands on a zeroed counter.
        err_count_d   = err_clr ? 16'd0 : err_count_q;
        match_count_d = err_clr ? 16'd0 : match_count_q;

        if (sample_valid) begin
            case (state_q)
                SEARCH: begin
                    exp_d   = lfsr_next(sample);
                    hits_d  = 4'd0;
                    state_d = VERIFY;
                end
                VERIFY: begin
                    exp_d = lfsr_next(sample);
                    if (sample == exp_q) begin
                        hits_d = hits_q + 4'd1;
                        if (hits_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        hits_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Prediction free-runs so a corrupted word cannot drag it off-sequence.
                    exp_d = lfsr_next(exp_q);
                    if (sample == exp_q) begin
                        miss_d        = 4'd0;
                        match_count_d = sat_inc(match_count_d);
                    end else begin
                        mismatch_d  = 1'b1;
                        err_count_d = sat_inc(err_count_d);
                        miss_d      = miss_q + 4'd1;
                        if (miss_q + 4'd1 == LOSS_N) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEARCH;
            exp_q         <= 12'h000;
            hits_q        <= 4'd0;
            miss_q        <= 4'd0;
            mismatch_q    <= 1'b0;
            err_count_q   <= 16'd0;
            match_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            hits_q        <= hits_d;
            miss_q        <= miss_d;
            mismatch_q    <= mismatch_d;
            err_count_q   <= err_count_d;
            match_count_q <= match_count_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign mismatch    = mismatch_q;
    assign err_count   = err_count_q;
    assign match_count = match_count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed-vector bench for lfsr_checker: default-parameter instance driven from a table,
// plus a LOSS_COUNT=15 instance for counter saturation and coincident clear.
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_reset, a_vld, a_clr;
    logic [11:0] a_smp;
    logic        a_locked, a_mm;
    logic [15:0] a_err, a_mat;
    logic [1:0]  a_state;

    lfsr_checker u_a (
        .clk(clk), .reset(a_reset), .sample_valid(a_vld), .sample(a_smp), .err_clr(a_clr),
        .locked(a_locked), .mismatch(a_mm), .err_count(a_err), .match_count(a_mat), .state(a_state)
    );

    // Instance B: long loss window so mismatches can be driven to saturation
    logic        b_reset, b_vld, b_clr;
    logic [11:0] b_smp;
    logic        b_locked, b_mm;
    logic [15:0] b_err, b_mat;
    logic [1:0]  b_state;

    lfsr_checker #(.LOSS_COUNT(15)) u_b (
        .clk(clk), .reset(b_reset), .sample_valid(b_vld), .sample(b_smp), .err_clr(b_clr),
        .locked(b_locked), .mismatch(b_mm), .err_count(b_err), .match_count(b_mat), .state(b_state)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic        clr;
        logic [11:0] smp;
        logic [1:0]  st;
        logic        lk;
        logic        mm;
        logic [15:0] err;
        logic [15:0] mat;
    } vec_t;

    vec_t vecs[31];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, want);
        end
    endtask

    function automatic logic [11:0] gen_next(input logic [11:0] x);
        return (x == 12'h000) ? 12'hB76 : {x[10:0], x[11] ^ x[10]};
    endfunction

    task automatic b_step(input logic rst, input logic vld, input logic clr, input logic [11:0] smp);
        @(negedge clk);
        b_reset = rst; b_vld = vld; b_clr = clr; b_smp = smp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] cur;
        logic [11:0] w;
        int          rounds;

        //            rst   vld   clr   smp       st    lk    mm    err     mat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'hB76, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h6ED, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 12'hDDB, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 12'hBB6, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 12'h76D, 2'd2, 1'b1, 1'b0, 16'd0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 12'hEDB, 2'd2, 1'b1, 1'b0, 16'd0, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 12'h000, 2'd2, 1'b1, 1'b1, 16'd1, 16'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 12'hB6C, 2'd2, 1'b1, 1'b0, 16'd1, 16'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12'h123, 2'd2, 1'b1, 1'b0, 16'd1, 16'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 12'h123, 2'd2, 1'b1, 1'b1, 16'd2, 16'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h123, 2'd2, 1'b1, 1'b1, 16'd3, 16'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 12'h123, 2'd0, 1'b0, 1'b1, 16'd4, 16'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 12'h123, 2'd1, 1'b0, 1'b0, 16'd4, 16'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 12'h000, 2'd1, 1'b0, 1'b0, 16'd4, 16'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 12'hB76, 2'd1, 1'b0, 1'b0, 16'd4, 16'd2};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 12'h6ED, 2'd1, 1'b0, 1'b0, 16'd4, 16'd2};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 12'hDDB, 2'd1, 1'b0, 1'b0, 16'd4, 16'd2};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 12'hBB6, 2'd2, 1'b1, 1'b0, 16'd4, 16'd2};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 12'h76D, 2'd2, 1'b1, 1'b0, 16'd0, 16'd1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 12'h000, 2'd2, 1'b1, 1'b0, 16'd0, 16'd0};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 12'h000, 2'd2, 1'b1, 1'b1, 16'd1, 16'd0};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 12'h000, 2'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 12'hDB6, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 12'hB6C, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[25] = '{1'b0, 1'b1, 1'b0, 12'h6D9, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[26] = '{1'b0, 1'b1, 1'b0, 12'h123, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[27] = '{1'b0, 1'b1, 1'b0, 12'h246, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[28] = '{1'b0, 1'b1, 1'b0, 12'h48C, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[29] = '{1'b0, 1'b1, 1'b0, 12'h919, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[30] = '{1'b0, 1'b1, 1'b0, 12'h233, 2'd2, 1'b1, 1'b0, 16'd0, 16'd0};

        a_reset = 1'b1; a_vld = 1'b0; a_clr = 1'b0; a_smp = 12'h000;
        b_reset = 1'b1; b_vld = 1'b0; b_clr = 1'b0; b_smp = 12'h000;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            a_reset = vecs[i].rst; a_vld = vecs[i].vld; a_clr = vecs[i].clr; a_smp = vecs[i].smp;
            @(posedge clk);
            #1;
            chk("state",       i, {14'd0, a_state}, {14'd0, vecs[i].st});
            chk("locked",      i, {15'd0, a_locked}, {15'd0, vecs[i].lk});
            chk("mismatch",    i, {15'd0, a_mm}, {15'd0, vecs[i].mm});
            chk("err_count",   i, a_err, vecs[i].err);
            chk("match_count", i, a_mat, vecs[i].mat);
        end
        @(negedge clk);
        a_vld = 1'b0; a_reset = 1'b0; a_clr = 1'b0;

        // Saturation: lock instance B, then 14 misses + 1 hit per round, never reaching loss.
        b_step(1'b1, 1'b0, 1'b0, 12'h000);
        w = 12'hB76;
        for (int k = 0; k < 5; k++) begin
            b_step(1'b0, 1'b1, 1'b0, w);
            w = gen_next(w);
        end
        chk("sat_lock", 100, {14'd0, b_state}, 16'd2);
        cur = w;
        rounds = 4682;
        for (int r = 0; r < rounds; r++) begin
            for (int m = 0; m < 14; m++) begin
                b_step(1'b0, 1'b1, 1'b0, cur ^ 12'h001);
                cur = gen_next(cur);
            end
            b_step(1'b0, 1'b1, 1'b0, cur);
            cur = gen_next(cur);
        end
        chk("sat_err_hold",  101, b_err, 16'hFFFF);
        chk("sat_match",     101, b_mat, 16'(rounds));
        chk("sat_locked",    101, {15'd0, b_locked}, 16'd1);

        b_step(1'b0, 1'b1, 1'b0, cur ^ 12'h001);
        cur = gen_next(cur);
        chk("sat_pulse",     102, {15'd0, b_mm}, 16'd1);
        chk("sat_err_stay",  102, b_err, 16'hFFFF);

        b_step(1'b0, 1'b1, 1'b1, cur ^ 12'h001);
        cur = gen_next(cur);
        chk("clr_err",       103, b_err, 16'd1);
        chk("clr_match",     103, b_mat, 16'd0);
        chk("clr_pulse",     103, {15'd0, b_mm}, 16'd1);
        chk("clr_state",     103, {14'd0, b_state}, 16'd2);

        b_step(1'b0, 1'b0, 1'b0, 12'h000);
        chk("idle_no_pulse", 104, {15'd0, b_mm}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
